// File: rtl/alu_share_ctrl.sv
// Arbiter/sequencer that time-shares one combinational RV32 ALU between two
// requesters: accept, drive the ALU for one cycle, then hold the result until taken.
module alu_share_ctrl #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req_valid_0,
    output logic             req_ready_0,
    input  logic [XLEN-1:0]  req_a_0,
    input  logic [XLEN-1:0]  req_b_0,
    input  logic [2:0]       req_funct3_0,
    input  logic [6:0]       req_funct7_0,

    input  logic             req_valid_1,
    output logic             req_ready_1,
    input  logic [XLEN-1:0]  req_a_1,
    input  logic [XLEN-1:0]  req_b_1,
    input  logic [2:0]       req_funct3_1,
    input  logic [6:0]       req_funct7_1,

    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [2:0]       alu_funct3,
    output logic [6:0]       alu_funct7,
    input  logic [XLEN-1:0]  alu_result,

    output logic             resp_valid_0,
    output logic             resp_valid_1,
    output logic [XLEN-1:0]  resp_data,
    input  logic             resp_ready_0,
    input  logic             resp_ready_1,

    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [6:0]        funct7_q, funct7_d;
    logic [XLEN-1:0]   resp_data_q, resp_data_d;
    logic [CNT_W-1:0]  ops_done_q, ops_done_d;

    logic              grant;
    logic              handshake;
    logic              resp_fire;

    // On a tie the port that did not win last time gets the ALU.
    always_comb begin
        if (req_valid_0 && req_valid_1) begin
            grant = ~last_grant_q;
        end else begin
            grant = req_valid_1;
        end
        handshake = (state_q == IDLE) && (req_valid_0 || req_valid_1);
        resp_fire = (state_q == RESP) && (owner_q ? resp_ready_1 : resp_ready_0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (handshake) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (resp_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_0  = (state_q == IDLE) && !grant && req_valid_0;
        req_ready_1  = (state_q == IDLE) &&  grant && req_valid_1;
        resp_valid_0 = (state_q == RESP) && !owner_q;
        resp_valid_1 = (state_q == RESP) &&  owner_q;
        busy         = (state_q != IDLE);
        alu_a        = a_q;
        alu_b        = b_q;
        alu_funct3   = funct3_q;
        alu_funct7   = funct7_q;
        resp_data    = resp_data_q;
        ops_done     = ops_done_q;
    end

    always_comb begin
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        a_d          = a_q;
        b_d          = b_q;
        funct3_d     = funct3_q;
        funct7_d     = funct7_q;
        resp_data_d  = resp_data_q;
        ops_done_d   = ops_done_q;
        if (handshake) begin
            owner_d      = grant;
            last_grant_d = grant;
            a_d          = grant ? req_a_1      : req_a_0;
            b_d          = grant ? req_b_1      : req_b_0;
            funct3_d     = grant ? req_funct3_1 : req_funct3_0;
            funct7_d     = grant ? req_funct7_1 : req_funct7_0;
        end
        if (state_q == EXEC) begin
            resp_data_d = alu_result;
        end
        if (resp_fire) begin
            ops_done_d = ops_done_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            funct3_q     <= '0;
            funct7_q     <= '0;
            resp_data_q  <= '0;
            ops_done_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            a_q          <= a_d;
            b_q          <= b_d;
            funct3_q     <= funct3_d;
            funct7_q     <= funct7_d;
            resp_data_q  <= resp_data_d;
            ops_done_q   <= ops_done_d;
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl; a small RV32 ALU model closes the loop and a
// second instance with a 2-bit counter covers wrap-around.
module tb_alu_share_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        v0, v1, rr0, rr1;
    logic [31:0] a0, b0, a1, b1;
    logic [2:0]  f30, f31;
    logic [6:0]  f70, f71;

    logic        rdy0, rdy1, rv0, rv1, busy;
    logic [31:0] alu_a, alu_b, alu_res, rdata;
    logic [2:0]  alu_f3;
    logic [6:0]  alu_f7;
    logic [15:0] ops;

    logic        w_rdy0, w_rdy1, w_rv0, w_rv1, w_busy;
    logic [31:0] w_alu_a, w_alu_b, w_alu_res, w_rdata;
    logic [2:0]  w_alu_f3;
    logic [6:0]  w_alu_f7;
    logic [1:0]  w_ops;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] f3, input logic [6:0] f7);
        case (f3)
            3'd0:    return f7[5] ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return {31'd0, $signed(a) < $signed(b)};
            3'd3:    return {31'd0, a < b};
            3'd4:    return a ^ b;
            3'd5:    return f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    assign alu_res   = alu_model(alu_a, alu_b, alu_f3, alu_f7);
    assign w_alu_res = alu_model(w_alu_a, w_alu_b, w_alu_f3, w_alu_f7);

    alu_share_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid_0(v0), .req_ready_0(rdy0), .req_a_0(a0), .req_b_0(b0),
        .req_funct3_0(f30), .req_funct7_0(f70),
        .req_valid_1(v1), .req_ready_1(rdy1), .req_a_1(a1), .req_b_1(b1),
        .req_funct3_1(f31), .req_funct7_1(f71),
        .alu_a(alu_a), .alu_b(alu_b), .alu_funct3(alu_f3), .alu_funct7(alu_f7),
        .alu_result(alu_res),
        .resp_valid_0(rv0), .resp_valid_1(rv1), .resp_data(rdata),
        .resp_ready_0(rr0), .resp_ready_1(rr1),
        .busy(busy), .ops_done(ops)
    );

    alu_share_ctrl #(.XLEN(32), .CNT_W(2)) dut_w (
        .clk(clk), .reset(reset),
        .req_valid_0(v0), .req_ready_0(w_rdy0), .req_a_0(a0), .req_b_0(b0),
        .req_funct3_0(f30), .req_funct7_0(f70),
        .req_valid_1(v1), .req_ready_1(w_rdy1), .req_a_1(a1), .req_b_1(b1),
        .req_funct3_1(f31), .req_funct7_1(f71),
        .alu_a(w_alu_a), .alu_b(w_alu_b), .alu_funct3(w_alu_f3), .alu_funct7(w_alu_f7),
        .alu_result(w_alu_res),
        .resp_valid_0(w_rv0), .resp_valid_1(w_rv1), .resp_data(w_rdata),
        .resp_ready_0(rr0), .resp_ready_1(rr1),
        .busy(w_busy), .ops_done(w_ops)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        v0 = 1'b0; v1 = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        v0 = 0; v1 = 0; rr0 = 0; rr1 = 0;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0; f30 = 0; f31 = 0; f70 = 0; f71 = 0;
        reset = 1'b1;
        #12;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if ({rv0, rv1} !== 2'b00) begin bad++; $display("FAIL reset_resp_valid: got %b want 00", {rv0, rv1}); end
        total++; if (ops !== 16'd0) begin bad++; $display("FAIL reset_ops: got %0d want 0", ops); end
        total++; if ({alu_a, alu_b} !== 64'd0) begin bad++; $display("FAIL reset_alu_ab: got %h/%h want 0/0", alu_a, alu_b); end
        total++; if ({rdy0, rdy1, rdata} !== 34'd0) begin bad++; $display("FAIL reset_misc: got %b%b %h want 00 0", rdy0, rdy1, rdata); end
        @(posedge clk); #1;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        rr0 = 1; rr1 = 1;
        a0 = 32'd5; b0 = 32'd3; f30 = 3'd0; f70 = 7'h20; v0 = 1;
        #1;
        total++; if ({rdy0, rdy1} !== 2'b10) begin bad++; $display("FAIL single_ready: got %b want 10", {rdy0, rdy1}); end
        tick();
        v0 = 0;
        total++; if ({alu_a, alu_b} !== {32'd5, 32'd3}) begin bad++; $display("FAIL single_alu_ab: got %h/%h want 5/3", alu_a, alu_b); end
        total++; if ({alu_f3, alu_f7} !== {3'd0, 7'h20}) begin bad++; $display("FAIL single_alu_funct: got %h/%h want 0/20", alu_f3, alu_f7); end
        total++; if ({busy, rv0} !== 2'b10) begin bad++; $display("FAIL single_exec: got busy=%b rv0=%b want 1 0", busy, rv0); end
        tick();
        total++; if ({rv0, rv1} !== 2'b10) begin bad++; $display("FAIL single_resp_valid: got %b want 10", {rv0, rv1}); end
        total++; if (rdata !== 32'd2) begin bad++; $display("FAIL single_resp_data: got %h want 2", rdata); end
        tick();
        total++; if (ops !== 16'd1) begin bad++; $display("FAIL single_ops: got %0d want 1", ops); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_tie();
        logic exp_grant;
        apply_reset();
        rr0 = 1; rr1 = 1;
        a0 = 32'd1; b0 = 32'd1; f30 = 3'd0; f70 = 7'h00; v0 = 1;
        a1 = 32'hF0; b1 = 32'h0F; f31 = 3'd4; f71 = 7'h00; v1 = 1;
        #1;
        total++; if ({rdy0, rdy1} !== 2'b10) begin bad++; $display("FAIL tie_first_ready: got %b want 10", {rdy0, rdy1}); end
        tick();
        v0 = 0;
        tick();
        total++; if ({rv0, rv1, rdata} !== {2'b10, 32'd2}) begin bad++; $display("FAIL tie_first_resp: got %b %h want 10 2", {rv0, rv1}, rdata); end
        tick();
        total++; if ({rdy0, rdy1} !== 2'b01) begin bad++; $display("FAIL tie_second_ready: got %b want 01", {rdy0, rdy1}); end
        tick();
        v1 = 0;
        tick();
        total++; if ({rv0, rv1, rdata} !== {2'b01, 32'hFF}) begin bad++; $display("FAIL tie_second_resp: got %b %h want 01 ff", {rv0, rv1}, rdata); end
        tick();
        v0 = 1; v1 = 1;
        for (int i = 0; i < 4; i++) begin
            exp_grant = (i % 2) != 0;
            #1;
            total++; if ({rdy0, rdy1} !== {~exp_grant, exp_grant}) begin bad++; $display("FAIL alt_ready[%0d]: got %b want %b", i, {rdy0, rdy1}, {~exp_grant, exp_grant}); end
            tick();
            tick();
            total++; if ({rv0, rv1} !== {~exp_grant, exp_grant}) begin bad++; $display("FAIL alt_resp[%0d]: got %b want %b", i, {rv0, rv1}, {~exp_grant, exp_grant}); end
            tick();
        end
        v0 = 0; v1 = 0;
        total++; if (ops !== 16'd6) begin bad++; $display("FAIL alt_ops: got %0d want 6", ops); end
    endtask

    task automatic test_backpressure();
        rr0 = 1; rr1 = 0;
        a1 = 32'h8000_0000; b1 = 32'd4; f31 = 3'd5; f71 = 7'h20; v1 = 1;
        tick();
        v1 = 0;
        a0 = 32'd7; b0 = 32'd8; f30 = 3'd0; f70 = 7'h00; v0 = 1;
        #1;
        total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL bp_exec_ready0: got %b want 0", rdy0); end
        tick();
        for (int i = 0; i < 5; i++) begin
            total++; if ({rv0, rv1} !== 2'b01) begin bad++; $display("FAIL bp_valid[%0d]: got %b want 01", i, {rv0, rv1}); end
            total++; if (rdata !== 32'hF800_0000) begin bad++; $display("FAIL bp_data[%0d]: got %h want f8000000", i, rdata); end
            total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL bp_ready0[%0d]: got %b want 0", i, rdy0); end
            tick();
        end
        total++; if (ops !== 16'd6) begin bad++; $display("FAIL bp_ops_held: got %0d want 6", ops); end
        rr1 = 1;
        tick();
        total++; if (ops !== 16'd7) begin bad++; $display("FAIL bp_ops_release: got %0d want 7", ops); end
        total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL bp_pending_ready0: got %b want 1", rdy0); end
        tick();
        v0 = 0;
        tick();
        total++; if ({rv0, rdata} !== {1'b1, 32'd15}) begin bad++; $display("FAIL bp_pending_resp: got %b %h want 1 f", rv0, rdata); end
        tick();
    endtask

    task automatic test_operand_change();
        rr0 = 1; rr1 = 1;
        a0 = 32'd1; b0 = 32'hFFFF_FFFF; f30 = 3'd3; f70 = 7'h00; v0 = 1;
        tick();
        v0 = 0;
        a0 = 32'hFFFF_FFFF;
        total++; if (alu_a !== 32'd1) begin bad++; $display("FAIL opchg_alu_a: got %h want 1", alu_a); end
        tick();
        total++; if ({rv0, rdata} !== {1'b1, 32'd1}) begin bad++; $display("FAIL opchg_resp: got %b %h want 1 1", rv0, rdata); end
        tick();
        total++; if (alu_a !== 32'd1) begin bad++; $display("FAIL opchg_alu_hold: got %h want 1", alu_a); end
    endtask

    task automatic test_reset_midop();
        rr0 = 1; rr1 = 1;
        a0 = 32'd9; b0 = 32'd9; f30 = 3'd0; f70 = 7'h00; v0 = 1;
        tick();
        v0 = 0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midop_exec: got busy=%b want 1", busy); end
        reset = 1'b1;
        #1;
        total++; if ({busy, rv0, rv1} !== 3'b000) begin bad++; $display("FAIL midop_reset_state: got %b want 000", {busy, rv0, rv1}); end
        total++; if (ops !== 16'd0) begin bad++; $display("FAIL midop_reset_ops: got %0d want 0", ops); end
        tick();
        reset = 1'b0;
        tick();
        total++; if ({rv0, rv1, busy} !== 3'b000) begin bad++; $display("FAIL midop_no_resp: got %b want 000", {rv0, rv1, busy}); end
        a0 = 32'd2; b0 = 32'd3; f30 = 3'd0; v0 = 1;
        a1 = 32'd4; b1 = 32'd4; f31 = 3'd6; f71 = 7'h00; v1 = 1;
        #1;
        total++; if ({rdy0, rdy1} !== 2'b10) begin bad++; $display("FAIL midop_tie_ready: got %b want 10", {rdy0, rdy1}); end
        tick();
        v0 = 0; v1 = 0;
        tick();
        total++; if ({rv0, rdata} !== {1'b1, 32'd5}) begin bad++; $display("FAIL midop_tie_resp: got %b %h want 1 5", rv0, rdata); end
        tick();
    endtask

    task automatic test_wrap();
        logic [1:0] exp_seq [5];
        exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        apply_reset();
        rr0 = 1; rr1 = 1;
        for (int i = 0; i < 5; i++) begin
            a0 = 32'(i); b0 = 32'd1; f30 = 3'd0; f70 = 7'h00; v0 = 1;
            tick();
            v0 = 0;
            tick();
            total++; if (w_rdata !== 32'(i + 1)) begin bad++; $display("FAIL wrap_data[%0d]: got %h want %h", i, w_rdata, i + 1); end
            tick();
            total++; if (w_ops !== exp_seq[i]) begin bad++; $display("FAIL wrap_ops[%0d]: got %0d want %0d", i, w_ops, exp_seq[i]); end
        end
        total++; if (ops !== 16'd5) begin bad++; $display("FAIL wrap_wide_ops: got %0d want 5", ops); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_backpressure();
        test_operand_change();
        test_reset_midop();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
